// File: rtl/wordred_final_32_pkg.sv
// Shared constants and the modulus builder for the final word-reduction canonicaliser.
package wordred_pkg;

  localparam int QL_W       = 13;
  localparam int QH_W       = 19;
  localparam int Q_W        = 32;
  localparam int I_SIZE_MIN = 34;

  // The low modulus word is fixed at 1, so q is always odd and fully set by qH.
  function automatic logic [Q_W-1:0] mk_q(input logic [QH_W-1:0] qh);
    return {qh, {{(QL_W-1){1'b0}}, 1'b1}};
  endfunction

endpackage

// File: rtl/wordred_final_32_red_sub_stage.sv
// One conditional-subtract pipeline register: data = (up >= K*q) ? up - K*q : up.
module red_sub_stage
  import wordred_pkg::*;
#(
  parameter int K     = 1,
  parameter int W     = I_SIZE_MIN,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             up_valid,
  input  logic [W-1:0]     up_data,
  input  logic [TAG_W-1:0] up_tag,
  input  logic [W-1:0]     q,
  output logic             valid,
  output logic [W-1:0]     data,
  output logic [TAG_W-1:0] tag
);

  localparam logic [W-1:0] K_W = W'(K);

  logic [W-1:0]     kq;
  logic [W-1:0]     sub;
  logic             valid_d, valid_q;
  logic [W-1:0]     data_d, data_q;
  logic [TAG_W-1:0] tag_d, tag_q;

  assign kq  = q * K_W;
  assign sub = (up_data >= kq) ? (up_data - kq) : up_data;

  // A load with no upstream beat inserts a bubble; data and tag keep their old value.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (load) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = sub;
        tag_d  = up_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign tag   = tag_q;

endmodule

// File: rtl/wordred_final_32.sv
// Two-stage stallable canonicaliser mapping T in [0,4q) to T mod q with tag pass-through.
// Optional range-violation flag enabled by defining RANGE_CHK_EN.
module wordred_final_32
  import wordred_pkg::*;
#(
  parameter int I_SIZE = 34,
  parameter int O_SIZE = 32,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [QH_W-1:0]   qH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [I_SIZE-1:0] T,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [O_SIZE-1:0] R,
  output logic [TAG_W-1:0]  out_tag,
  output logic              err
);

  logic [I_SIZE-1:0] q_ext;
  logic              s1_load, s2_load;
  logic              v1, v2;
  logic [I_SIZE-1:0] t1, t2;
  logic [TAG_W-1:0]  tag1, tag2;

  assign q_ext = I_SIZE'(mk_q(qH));

  // Valid/ready: a beat moves on any rising edge where valid and ready are both high.
  // Ready ripples back combinationally from out_ready through the two load terms only.
  assign s2_load  = !v2 || out_ready;
  assign s1_load  = !v1 || s2_load;
  assign in_ready = rst && s1_load;

  red_sub_stage #(.K(2), .W(I_SIZE), .TAG_W(TAG_W)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .load     (s1_load),
    .up_valid (in_valid),
    .up_data  (T),
    .up_tag   (in_tag),
    .q        (q_ext),
    .valid    (v1),
    .data     (t1),
    .tag      (tag1)
  );

  red_sub_stage #(.K(1), .W(I_SIZE), .TAG_W(TAG_W)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .load     (s2_load),
    .up_valid (v1),
    .up_data  (t1),
    .up_tag   (tag1),
    .q        (q_ext),
    .valid    (v2),
    .data     (t2),
    .tag      (tag2)
  );

  assign out_valid = v2;
  assign R         = O_SIZE'(t2);
  assign out_tag   = tag2;

  // The top bits of t2 are zero for in-range input and are dropped by design.
  generate
    if (O_SIZE < I_SIZE) begin : g_drop_hi
      logic unused_t2_hi;
      assign unused_t2_hi = ^t2[I_SIZE-1:O_SIZE];
    end
  endgenerate

`ifdef RANGE_CHK_EN
  logic [I_SIZE-1:0] q4;
  logic              f1_d, f1_q;
  logic              f2_d, f2_q;
  logic              err_d, err_q;

  assign q4 = q_ext << 2;

  always_comb begin
    f1_d  = f1_q;
    f2_d  = f2_q;
    if (s1_load && in_valid) f1_d = (T >= q4);
    if (s2_load && v1)       f2_d = f1_q;
    err_d = err_q || (v2 && out_ready && f2_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      f1_q  <= 1'b0;
      f2_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      f1_q  <= f1_d;
      f2_q  <= f2_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/wordred_final_32.md
Name: wordred_final_32

Overview:
- Final canonicalisation stage directly downstream of the last word-level Montgomery reduction step in the butterfly unit.
- The modulus is q = {qH, 13'd1}, 32 bits. The upstream reduction word T is unsigned and lies in [0, 4q).
- This block maps T to the canonical residue in [0, q) through a 2-stage stallable pipeline with valid/ready handshake and tag pass-through.
- Its result feeds the butterfly output and memory write-back.

Parameters:
- I_SIZE, 34, width of incoming reduced word T (must be >= 34).
- O_SIZE, 32, width of canonical output (must be >= 32).
- TAG_W, 8, width of sideband tag (coefficient index / lane id) carried alongside data.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- qH  in  19  upper modulus bits; q = {qH,13'd1}; quasi-static, changes only while pipeline empty.
- in_valid  in  1  T/in_tag valid.
- in_ready  out  1  stage can accept this cycle.
- T  in  I_SIZE  reduced word from upstream, expected in [0,4q).
- in_tag  in  TAG_W  sideband travelling with T.
- out_valid  out  1  R/out_tag valid.
- out_ready  in  1  downstream accepts this cycle.
- R  out  O_SIZE  canonical residue in [0,q), zero-extended.
- out_tag  out  TAG_W  tag matching R.
- err  out  1  sticky range-violation flag (see Optional Feature).

Behaviour:
- Transfer occurs when valid & ready are both high on a rising edge; both interfaces obey this rule.
- Stage 1 (S1):
  - on accept, register t1 = (T >= 2q) ? T - 2q : T, together with in_tag and v1 = 1.
  - compare and subtract at I_SIZE width, unsigned.
- Stage 2 (S2):
  - register t2 = (t1 >= q) ? t1 - q : t1, together with the tag and v2 = 1.
  - R = t2[O_SIZE-1:0]; out_valid = v2.
- Latency: 2 cycles from input handshake to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Stall rules:
  - S2 loads when !v2 | out_ready.
  - S1 loads when !v1 | S2 loads.
  - in_ready = !v1 | S2 loads (combinational from out_ready; no other comb paths).
- Bubbles:
  - a stage whose upstream is invalid while it loads clears its valid bit.
  - data registers of invalid stages hold their last value.
- Simultaneous events:
  - input accept and output drain in the same cycle: both occur; no beat lost or duplicated.
  - order is strictly FIFO.
- Full pipeline with out_ready = 0: v1 = v2 = 1, in_ready = 0, and R/out_tag stay stable until the handshake.
- Reset (rst = 0), including mid-operation:
  - next edge sets v1 = v2 = 0, t1 = t2 = 0, tags = 0, err = 0.
  - out_valid = 0, R = 0, out_tag = 0, in_ready = 0 during reset.
  - any in-flight beats are discarded.
- Out-of-range input (T >= 4q):
  - data path still computes as above, so R = T - 3q truncated; for example T = 4q gives R = q.
  - no stall and no drop.

Optional Feature:
- Macro RANGE_CHK_EN.
- Defined:
  - S1 also registers flag f1 = (T >= 4q), and S2 forwards it.
  - err sets on the cycle the flagged beat completes its output handshake and stays 1 until reset.
- Undefined: err tied to 0; no comparator or flag registers are synthesised.

Decomposition:
- Package wordred_pkg:
  - constants QL_W = 13, QH_W = 19, Q_W = 32.
  - function mk_q(qH) returning {qH,13'd1}.
  - shared localparams for I_SIZE minimum (34).
- Sub-module red_sub_stage:
  - parameterised by subtract multiple K (2 or 1).
  - one conditional-subtract register stage with valid/load logic and tag.
  - instantiated twice.

Test Plan (qH = 19'h3FF01 → q = 0x7FE02001, 2q = 0xFFC04002, 4q = 0x1FF808004):
- T = 5, tag 0x11, out_ready = 1 → R = 5, out_tag 0x11, out_valid exactly 2 cycles after accept.
- T = q → R = 0; T = 2q + 7 (0xFFC04009) → R = 7; T = 4q - 1 (0x1FF808003) → R = 0x7FE02000.
- Stream 6 back-to-back values with out_ready low for cycles 3-5:
  - in_ready drops once 2 beats are held.
  - R and out_tag are stable while stalled.
  - all 6 results arrive in order with no loss.
- Accept and drain in the same cycle under continuous flow for 100 random T in [0,4q) → every R equals T mod q, one result per cycle.
- Pull rst low with 2 beats in flight:
  - next cycle out_valid = 0, R = 0, err = 0.
  - first post-reset beat T = 9 → R = 9 after 2 cycles.
- With RANGE_CHK_EN, T = 4q:
  - R = 0x7FE02001, err rises after its output handshake and stays high.
  - a later valid T leaves err at 1.
  - without the macro, err stays 0.
